// File: rtl/iq_block_scheduler.sv
// ---------------------------------------------------------------------------
// iq_block_scheduler
//
// Shares one combinational inverse-quantizer between a luma and a chroma
// requester. Arbitration is round-robin at block granularity: once a source
// is granted it keeps the quantizer for all BLK_SIZE coefficients of its
// block. The block QP is captured on the first beat. Dequantized results are
// registered into a valid/ready output stream tagged with source and
// end-of-block.
//
// Ports
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   req_valid_i / req_ready_o  per-source handshake (bit0 luma, bit1 chroma)
//   req_coeff0_i / req_coeff1_i quantized coefficient per source
//   req_qp0_i / req_qp1_i      QP per source, used on the first beat only
//   iq_coeff_o / iq_qp_o       operands driven into the shared quantizer
//   iq_result_i                combinational quantizer result
//   out_valid_o / out_ready_i  output stream handshake
//   out_coeff_o                dequantized coefficient
//   out_src_o                  0 luma, 1 chroma
//   out_last_o                 coefficient BLK_SIZE-1 of its block
//   qp_err_o                   one-cycle pulse when a latched block QP >= 52
// ---------------------------------------------------------------------------
module iq_block_scheduler #(
    parameter int COEFF_WIDTH = 16,
    parameter int QP_WIDTH    = 6,
    parameter int BLK_SIZE    = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [1:0]             req_valid_i,
    output logic [1:0]             req_ready_o,
    input  logic [COEFF_WIDTH-1:0] req_coeff0_i,
    input  logic [COEFF_WIDTH-1:0] req_coeff1_i,
    input  logic [QP_WIDTH-1:0]    req_qp0_i,
    input  logic [QP_WIDTH-1:0]    req_qp1_i,
    output logic [COEFF_WIDTH-1:0] iq_coeff_o,
    output logic [QP_WIDTH-1:0]    iq_qp_o,
    input  logic [COEFF_WIDTH-1:0] iq_result_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [COEFF_WIDTH-1:0] out_coeff_o,
    output logic                   out_src_o,
    output logic                   out_last_o,
    output logic                   qp_err_o
);

    localparam int CNT_W = $clog2(BLK_SIZE);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BLK_SIZE - 1);

    typedef enum logic {
        IDLE,
        BURST
    } state_e;

    state_e                 state_q;
    logic                   grant_q;
    logic                   rrPtr_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic [QP_WIDTH-1:0]    blkQp_q;
    logic [COEFF_WIDTH-1:0] outCoeff_q;
    logic                   outSrc_q;
    logic                   outLast_q;
    logic                   outValid_q;
    logic                   qpErr_q;

    logic                   grantValid;
    logic [COEFF_WIDTH-1:0] grantCoeff;
    logic [QP_WIDTH-1:0]    grantQp;
    logic                   outFree;
    logic                   inBurst;
    logic                   accept;
    logic                   lastBeat;
    logic                   firstBeat;
    logic                   nextGrant;

    // Datapath steering and handshake. The output register is free when it
    // is empty or being drained this cycle, which gives full throughput and
    // keeps req_ready independent of req_valid.
    always_comb begin
        grantValid  = grant_q ? req_valid_i[1] : req_valid_i[0];
        grantCoeff  = grant_q ? req_coeff1_i : req_coeff0_i;
        grantQp     = grant_q ? req_qp1_i : req_qp0_i;
        outFree     = !outValid_q || out_ready_i;
        inBurst     = (state_q == BURST);
        accept      = inBurst && grantValid && outFree;
        lastBeat    = (cnt_q == LAST_BEAT);
        firstBeat   = (cnt_q == '0);
        cnt_d       = cnt_q + CNT_W'(1);
        // Favoured source wins if it is asking, otherwise the other one.
        nextGrant   = req_valid_i[rrPtr_q] ? rrPtr_q : ~rrPtr_q;

        req_ready_o = 2'b00;
        if (inBurst && outFree) begin
            req_ready_o[grant_q] = 1'b1;
        end

        iq_coeff_o  = inBurst ? grantCoeff : '0;
        // Only the first beat sees the live QP; later beats use the latched
        // block QP so mid-block QP changes have no effect.
        iq_qp_o     = firstBeat ? grantQp : blkQp_q;
    end

    // Arbitration FSM, beat counter, block QP and the registered output
    // stage all live in this one block.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            grant_q    <= 1'b0;
            rrPtr_q    <= 1'b0;
            cnt_q      <= '0;
            blkQp_q    <= '0;
            outCoeff_q <= '0;
            outSrc_q   <= 1'b0;
            outLast_q  <= 1'b0;
            outValid_q <= 1'b0;
            qpErr_q    <= 1'b0;
        end else begin
            qpErr_q <= 1'b0;

            if (accept) begin
                outCoeff_q <= iq_result_i;
                outSrc_q   <= grant_q;
                outLast_q  <= lastBeat;
                outValid_q <= 1'b1;
                if (firstBeat) begin
                    blkQp_q <= grantQp;
                    qpErr_q <= (32'(grantQp) >= 32'd52);
                end
            end else if (out_ready_i) begin
                outValid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (|req_valid_i) begin
                        grant_q <= nextGrant;
                        cnt_q   <= '0;
                        state_q <= BURST;
                    end
                end
                BURST: begin
                    if (accept) begin
                        if (lastBeat) begin
                            rrPtr_q <= ~grant_q;
                            cnt_q   <= '0;
                            state_q <= IDLE;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_valid_o = outValid_q;
    assign out_coeff_o = outCoeff_q;
    assign out_src_o   = outSrc_q;
    assign out_last_o  = outLast_q;
    assign qp_err_o    = qpErr_q;

endmodule

// File: doc/iq_block_scheduler.md
# iq_block_scheduler

Sequences 16-coefficient transform blocks from two requesters (luma, chroma) through a single shared combinational inverse-quantizer instance in the camera decoder's inverse quant & transform stage. Arbitrates round-robin at block granularity, locks each grant for a full block, latches the block QP, and registers the dequantized results into a valid/ready output stream tagged with source and end-of-block.

## Interface
- COEFF_WIDTH, 16, signed coefficient width (input, quantizer and output)
- QP_WIDTH, 6, QP width
- BLK_SIZE, 16, coefficients per block (power of two, ≥2)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  2  per-source coefficient valid (bit0 luma, bit1 chroma)
- req_ready  out  2  per-source coefficient accept
- req_coeff0 / req_coeff1  in  COEFF_WIDTH each  quantized coefficient per source
- req_qp0 / req_qp1  in  QP_WIDTH each  QP per source, sampled on first beat of a block only
- iq_coeff  out  COEFF_WIDTH  operand to shared quantizer
- iq_qp  out  QP_WIDTH  QP to shared quantizer
- iq_result  in  COEFF_WIDTH  combinational quantizer result for iq_coeff/iq_qp
- out_valid  out  1  output coefficient valid
- out_ready  in  1  downstream accept
- out_coeff  out  COEFF_WIDTH  dequantized coefficient
- out_src  out  1  source of out_coeff (0 luma, 1 chroma)
- out_last  out  1  out_coeff is coefficient BLK_SIZE-1 of its block
- qp_err  out  1  one-cycle pulse: latched block QP ≥ 52

## Operation
- States: IDLE, BURST. Registers: grant (1b), rr_ptr (1b, favoured source), beat counter (log2 BLK_SIZE), blk_qp, output register (coeff/src/last/valid).
- IDLE: req_ready = 0. If any req_valid: grant = rr_ptr if req_valid[rr_ptr], else the other valid source; go BURST, counter = 0. Neither valid: stay.
- BURST: req_ready[grant] = (!out_valid || out_ready); other bit 0. Accept = req_valid[grant] && req_ready[grant].
- iq_coeff = req_coeff of grant (0 in IDLE). iq_qp = req_qp of grant when counter==0, else blk_qp.
- On accept: out_coeff ← iq_result, out_src ← grant, out_last ← (counter==BLK_SIZE-1), out_valid ← 1, counter += 1; when counter==0 also blk_qp ← req_qp of grant and qp_err pulses next cycle if that QP ≥ 52 (quantizer forces 0; scheduler passes results through unchanged).
- On accept of beat BLK_SIZE-1: rr_ptr ← ~grant, counter ← 0, go IDLE.
- Output register: out_valid cleared when out_ready && no new accept; simultaneous drain and accept reloads (full throughput).
- QP changes on req_qp mid-block are ignored; req_valid drop mid-block stalls the burst (no timeout, grant held).

## Timing
- Reset values: state IDLE, rr_ptr 0, grant 0, counter 0, blk_qp 0, out_valid 0, out_coeff 0, out_src 0, out_last 0, qp_err 0, req_ready 0.
- Latency: coefficient accepted in cycle N is on out_coeff with out_valid in cycle N+1.
- Arbitration: one IDLE bubble cycle per block; steady throughput BLK_SIZE beats per BLK_SIZE+1 cycles.
- Backpressure: out_valid && !out_ready holds the output register stable and forces req_ready = 0.
- req_ready depends combinationally on out_ready only; no dependency on req_valid.
- Reset asserted mid-burst: all state cleared immediately; partial block discarded, no out_last emitted.

## Test plan
- Luma only, 16 beats coeff=k (k=1..16), QP=0, out_ready=1 -> 16 outputs in 16 consecutive cycles after 1-cycle bubble, out_src=0, out_last only on 16th, first output one cycle after first accept.
- Both sources valid continuously, after reset -> blocks alternate luma, chroma, luma; each block 16 beats, no interleaving within a block.
- Luma QP=10 on beat 0, req_qp0 changed to 40 on beats 1..15 -> iq_qp=10 for all 16 beats.
- out_ready toggled 0/1 every cycle during a burst -> no beat lost or duplicated, out_coeff stable while stalled, order preserved.
- Chroma block with QP=52 -> qp_err one-cycle pulse the cycle after beat 0; all 16 out_coeff = 0 from quantizer.
- rst_n low after 7 beats of a luma block -> out_valid=0, state IDLE, next block restarts counter at 0 and rr_ptr=0.
